// File: rtl/infer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : infer_sequencer
//  Description : Frame sequencer for the combinational MNIST inference core.
//                Assembles a byte-streamed image into the core's frame
//                register, holds it stable for SETTLE cycles, then captures
//                the core result and offers it on a valid/ready port.
//  Revision    : 1.0  initial release
// ============================================================================
module infer_sequencer #(
  parameter int NPIX   = 784,
  parameter int PIXW   = 8,
  parameter int OUTW   = 10,
  parameter int SETTLE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [PIXW-1:0]        pix_data,
  input  logic                   pix_last,
  output logic [NPIX*PIXW-1:0]   frame_data,
  input  logic [OUTW-1:0]        model_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [OUTW-1:0]        res_data,
  output logic                   res_err,
  output logic                   busy
);

  localparam int c_PCW = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_PCW-1:0]  r_pcnt;
  logic [7:0]        r_scnt;
  logic              r_err_pend;
  logic [OUTW-1:0]   r_res_data;
  logic              r_res_err;
  logic [PIXW-1:0]   r_pix [NPIX];

  logic              w_beat;
  logic              w_final;
  logic              w_capture;

  assign w_beat    = pix_valid & pix_ready;
  assign w_final   = (r_pcnt == c_PCW'(NPIX - 1));
  assign w_capture = (r_state == S_SETTLE) && (r_scnt == 8'(SETTLE - 1));

  assign res_data  = r_res_data;
  assign res_err   = r_res_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded handshake outputs (rst only gates pix_ready)
  always_comb begin
    w_state_nxt = r_state;
    pix_ready   = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_LOAD: begin
        pix_ready = ~rst;
        if (w_beat && w_final) begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (w_capture) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  // Pixel/settle counters, sticky framing error and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt     <= '0;
      r_scnt     <= '0;
      r_err_pend <= 1'b0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_beat) begin
            if (w_final) begin
              // Final slot closes the frame whether or not pix_last marks it
              r_pcnt <= '0;
              r_scnt <= '0;
              if (!pix_last) begin
                r_err_pend <= 1'b1;
              end
            end else if (pix_last) begin
              // Short frame: abort, remember the error for the next result
              r_pcnt     <= '0;
              r_err_pend <= 1'b1;
            end else begin
              r_pcnt <= r_pcnt + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          r_scnt <= r_scnt + 8'd1;
          if (w_capture) begin
            r_res_data <= model_out;
            r_res_err  <= r_err_pend;
            r_err_pend <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Frame register: one byte slot per pixel, written only on its own beat
  for (genvar i = 0; i < NPIX; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (rst) begin
        r_pix[i] <= '0;
      end else if (w_beat && (r_pcnt == c_PCW'(i))) begin
        r_pix[i] <= pix_data;
      end
    end
    assign frame_data[i*PIXW +: PIXW] = r_pix[i];
  end

endmodule
`default_nettype wire
